instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/loader_pkg.sv | 15 +
 rtl/word_assembler.sv | 34 +++
 rtl/instruction_loader.sv | 137 +++++++++++++
 tb/tb_instruction_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the UART instruction loader
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      DONE,
      ERROR
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;
   localparam int         LEN_W     = 16;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs a little-endian byte stream into 32-bit words
module word_assembler (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic [7:0]  byte_data,
   input  logic        byte_valid,
   output logic [31:0] word,
   output logic        word_valid
);

   logic [1:0] idx;

   // Bytes shift in from the top so the first byte of a group ends up in [7:0].
   // word stays stable for the strobe cycle even if the next byte arrives then.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word       <= '0;
         idx        <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            word <= '0;
            idx  <= '0;
         end else if (byte_valid) begin
            word       <= {byte_data, word[31:8]};
            idx        <= idx + 2'd1;
            word_valid <= (idx == 2'd3);
         end
      end
   end

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - loads a length-prefixed program from UART bytes into instruction memory
module instruction_loader
   import loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int          MAX_WORDS      = 256,
   parameter int          TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [31:0] mem_byte_address,
   output logic        mem_write_enable,
   output logic [31:0] mem_write_data,
   output logic        loading,
   output logic        done,
   output logic        error
);

   localparam int BCNT_W = $clog2(MAX_WORDS * 4 + 3);
   localparam int WCNT_W = $clog2(MAX_WORDS + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [BCNT_W-1:0] BCNT_MAX = '1;
   localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   state_t            state;
   logic [BCNT_W-1:0] byte_cnt;
   logic [WCNT_W-1:0] words_left;
   logic [TO_W-1:0]   tcnt;
   logic [7:0]        len_lo;
   logic [LEN_W-1:0]  len_val;
   logic              asm_clear;
   logic              asm_valid;

   assign len_val   = {rx_data, len_lo};
   assign asm_clear = (state != DATA);
   assign asm_valid = rx_valid && (state == DATA);

   word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (asm_clear),
      .byte_data  (rx_data),
      .byte_valid (asm_valid),
      .word       (mem_write_data),
      .word_valid (mem_write_enable)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         loading          <= 1'b0;
         done             <= 1'b0;
         error            <= 1'b0;
         mem_byte_address <= BASE_ADDR;
         byte_cnt         <= '0;
         words_left       <= '0;
         tcnt             <= '0;
         len_lo           <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERROR: begin
               if (rx_valid && rx_data == SYNC_BYTE) begin
                  state    <= LEN;
                  loading  <= 1'b1;
                  done     <= 1'b0;
                  error    <= 1'b0;
                  byte_cnt <= '0;
                  tcnt     <= '0;
               end
            end

            LEN: begin
               if (rx_valid) begin
                  tcnt <= '0;
                  if (byte_cnt != BCNT_MAX) byte_cnt <= byte_cnt + 1'b1;
                  if (byte_cnt == '0) begin
                     len_lo <= rx_data;
                  end else if (len_val == '0) begin
                     state   <= DONE;
                     loading <= 1'b0;
                     done    <= 1'b1;
                  end else if (32'(len_val) > 32'(MAX_WORDS)) begin
                     state   <= ERROR;
                     loading <= 1'b0;
                     error   <= 1'b1;
                  end else begin
                     state            <= DATA;
                     mem_byte_address <= BASE_ADDR;
                     words_left       <= WCNT_W'(len_val);
                  end
               end else if (tcnt == TO_LAST) begin
                  state   <= ERROR;
                  loading <= 1'b0;
                  error   <= 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            DATA: begin
               if (rx_valid) begin
                  tcnt <= '0;
                  if (byte_cnt != BCNT_MAX) byte_cnt <= byte_cnt + 1'b1;
               end else if (tcnt == TO_LAST) begin
                  state   <= ERROR;
                  loading <= 1'b0;
                  error   <= 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
               // Strobe cycle: the write is on the bus now, so step past it.
               if (mem_write_enable) begin
                  mem_byte_address <= mem_byte_address + 32'd4;
                  if (words_left != '0) words_left <= words_left - 1'b1;
                  if (words_left == WCNT_W'(1)) begin
                     state   <= DONE;
                     loading <= 1'b0;
                     done    <= 1'b1;
                     error   <= 1'b0;
                  end
               end
            end

            default: begin
               state   <= IDLE;
               loading <= 1'b0;
               done    <= 1'b0;
               error   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - randomized and directed checks of instruction_loader against a protocol model
module tb_instruction_loader;

   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam int          MAXW   = 256;
   localparam int          TO_CYC = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [31:0] mem_byte_address;
   logic        mem_write_enable;
   logic [31:0] mem_write_data;
   logic        loading;
   logic        done;
   logic        error;

   int total = 0;
   int bad   = 0;

   logic [63:0] obs_q[$];
   logic [63:0] exp_q[$];
   logic        exp_done;
   logic        exp_err;
   int          wide_pulses = 0;
   logic        prev_we = 1'b0;

   instruction_loader #(
      .BASE_ADDR      (BASE),
      .MAX_WORDS      (MAXW),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .rx_data          (rx_data),
      .rx_valid         (rx_valid),
      .mem_byte_address (mem_byte_address),
      .mem_write_enable (mem_write_enable),
      .mem_write_data   (mem_write_data),
      .loading          (loading),
      .done             (done),
      .error            (error)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_write_enable) obs_q.push_back({mem_byte_address, mem_write_data});
      if (mem_write_enable && prev_we) wide_pulses <= wide_pulses + 1;
      prev_we <= mem_write_enable;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Protocol model: skip noise up to the sync byte, read the little-endian length, then words.
   task automatic model(input logic [7:0] q[$]);
      int s;
      int len;
      s = 0;
      exp_q.delete();
      while (s < q.size() && q[s] != 8'hA5) s++;
      len = int'(q[s+1]) + 256 * int'(q[s+2]);
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (len == 0) exp_done = 1'b1;
      else if (len > MAXW) exp_err = 1'b1;
      else begin
         for (int i = 0; i < len; i++) begin
            int b;
            logic [31:0] w;
            b = s + 3 + 4 * i;
            w = int'(q[b]) + (int'(q[b+1]) << 8) + (int'(q[b+2]) << 16) + (int'(q[b+3]) << 24);
            exp_q.push_back({BASE + 32'(4 * i), w});
         end
         exp_done = 1'b1;
      end
   endtask

   // Caller is at a negedge; gap=0 keeps rx_valid high across consecutive bytes.
   task automatic drive(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   // mode 0: back-to-back, 1: one idle cycle between bytes, 2: random gaps
   task automatic run_load(input string tag, input logic [7:0] q[$], input int mode);
      int w0;
      w0 = wide_pulses;
      obs_q.delete();
      for (int i = 0; i < q.size(); i++)
         drive(q[i], mode == 0 ? 0 : mode == 1 ? 1 : ($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 3)) : 0));
      for (int i = 0; i < 20 && !(done || error); i++) @(negedge clk);
      repeat (2) @(negedge clk);
      model(q);
      chk({tag, ".nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         chk({tag, ".addr"}, i < obs_q.size() ? obs_q[i][63:32] : 32'hxxxx_xxxx, exp_q[i][63:32]);
         chk({tag, ".data"}, i < obs_q.size() ? obs_q[i][31:0]  : 32'hxxxx_xxxx, exp_q[i][31:0]);
      end
      chk({tag, ".done"}, 32'(done), 32'(exp_done));
      chk({tag, ".error"}, 32'(error), 32'(exp_err));
      chk({tag, ".loading"}, 32'(loading), 32'd0);
      chk({tag, ".pulse1"}, 32'(wide_pulses - w0), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".we"},      32'(mem_write_enable), 32'd0);
      chk({tag, ".loading"}, 32'(loading), 32'd0);
      chk({tag, ".done"},    32'(done), 32'd0);
      chk({tag, ".error"},   32'(error), 32'd0);
      chk({tag, ".addr"},    mem_byte_address, BASE);
      chk({tag, ".wdata"},   mem_write_data, 32'd0);
   endtask

   task automatic rand_prog(output logic [7:0] q[$], input int nwords, input int noise);
      logic [7:0] nb;
      q.delete();
      for (int i = 0; i < noise; i++) begin
         nb = 8'($urandom_range(0, 255));
         q.push_back(nb == 8'hA5 ? 8'h5A : nb);
      end
      q.push_back(8'hA5);
      q.push_back(8'(nwords));
      q.push_back(8'(nwords >> 8));
      for (int i = 0; i < 4 * nwords; i++) q.push_back(8'($urandom_range(0, 255)));
   endtask

   initial begin
      logic [7:0] q[$];
      int w0;

      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      run_load("two_words", q, 1);
      chk("two_words.w0", obs_q.size() > 0 ? obs_q[0][31:0] : 32'hx, 32'h0000_0013);
      chk("two_words.w1", obs_q.size() > 1 ? obs_q[1][31:0] : 32'hx, 32'h0010_0093);

      q = '{8'hA5, 8'h00, 8'h00};
      run_load("zero_len", q, 1);

      q = '{8'hA5, 8'h01, 8'h01};
      run_load("too_long", q, 0);

      // Timeout: two data bytes of a one-word load, then silence.
      obs_q.delete();
      q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
      for (int i = 0; i < q.size(); i++) drive(q[i], 0);
      repeat (50) @(negedge clk);
      chk("timeout.mid_loading", 32'(loading), 32'd1);
      chk("timeout.mid_error", 32'(error), 32'd0);
      repeat (60) @(negedge clk);
      chk("timeout.error", 32'(error), 32'd1);
      chk("timeout.loading", 32'(loading), 32'd0);
      chk("timeout.nwrites", 32'(obs_q.size()), 32'd0);

      rand_prog(q, 3, 0);
      run_load("after_timeout", q, 1);

      for (int it = 0; it < 6; it++) begin
         rand_prog(q, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
         run_load("rand", q, it < 3 ? 0 : 2);
      end

      rand_prog(q, MAXW, 0);
      run_load("max_words", q, 0);

      // Reset in the middle of the data phase.
      obs_q.delete();
      w0 = wide_pulses;
      q = '{8'hA5, 8'h02, 8'h00, 8'hDE, 8'hAD};
      for (int i = 0; i < q.size(); i++) drive(q[i], 0);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      drive(8'hBE, 0);
      drive(8'hEF, 0);
      repeat (3) @(negedge clk);
      chk("mid_reset.nwrites", 32'(obs_q.size()), 32'd0);
      chk("mid_reset.pulse1", 32'(wide_pulses - w0), 32'd0);
      rand_prog(q, 2, 1);
      run_load("post_reset", q, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
